// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid
// Purpose  : Circular landing buffer with occupancy count for returning FIFO
//            read data; head entry is presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [CNT_WIDTH-1:0]  o_count
);
    localparam int c_PW = $clog2(DEPTH);
    localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]       r_head;
    logic [c_PW-1:0]       r_tail;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_pop;

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + c_PW'(1);
    endfunction

    assign w_pop   = i_rd && (r_count != '0);
    assign o_rdata = r_mem[r_head];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_wr)
                r_tail <= f_next(r_tail);
            if (w_pop)
                r_head <= f_next(r_head);
            case ({i_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset; only the head entry is ever observed
    // and only while the count is non-zero.
    always_ff @(posedge clk) begin
        if (i_wr)
            r_mem[r_tail] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Purpose  : Converts a pmi_fifo read port into a valid/ready stream with
//            start/end-of-line framing and a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int LINE_LEN   = 640,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] FifoQ,
    input  logic                  FifoEmpty,
    output logic                  FifoRdEn,
    input  logic                  Flush,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  OutSol,
    output logic                  OutEol
);
    localparam int c_DEPTH = RD_LATENCY + 2;
    localparam int c_CW    = $clog2(c_DEPTH + 1);
    localparam logic [c_CW:0]          c_DEPTH_V = (c_CW + 1)'(c_DEPTH);
    localparam logic [LEN_WIDTH-1:0]   c_LAST    = LEN_WIDTH'(LINE_LEN - 1);

    logic [RD_LATENCY-1:0] r_tok;
    logic                  r_live;
    logic [LEN_WIDTH-1:0]  r_col;
    logic [c_CW-1:0]       w_occ;
    logic [c_CW-1:0]       w_inflight;
    logic [c_CW:0]         w_pending;
    logic                  w_capture;
    logic                  w_xfer;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < RD_LATENCY; k++)
            w_inflight = w_inflight + c_CW'(r_tok[k]);
    end

    // Reads are only issued when every outstanding word already has a slot,
    // so a capture can never land on a full buffer.
    assign w_pending = {1'b0, w_occ} + {1'b0, w_inflight};
    assign FifoRdEn  = r_live && !FifoEmpty && !Flush && (w_pending < c_DEPTH_V);
    assign w_capture = r_tok[RD_LATENCY-1];
    assign OutValid  = (w_occ != '0);
    assign w_xfer    = OutValid && OutReady;
    assign OutSol    = (r_col == '0);
    assign OutEol    = (r_col == c_LAST);

    // r_live holds off reads for the first cycle after reset release.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_tok  <= '0;
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (Flush)
                r_tok <= '0;
            else
                r_tok <= (r_tok << 1) | RD_LATENCY'(FifoRdEn);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            r_col <= '0;
        else if (Flush)
            r_col <= '0;
        else if (w_xfer)
            r_col <= (r_col == c_LAST) ? '0 : r_col + LEN_WIDTH'(1);
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (c_DEPTH),
        .CNT_WIDTH  (c_CW)
    ) u_skid (
        .clk     (Clock),
        .rst_n   (Reset),
        .i_flush (Flush),
        .i_wr    (w_capture),
        .i_wdata (FifoQ),
        .i_rd    (w_xfer),
        .o_rdata (OutData),
        .o_count (w_occ)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Purpose  : Self-checking bench; two DUTs (read latency 1 and 2, 4-word lines)
//            fed from behavioural pmi_fifo models and scored against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;
    localparam int MS   = 32768;
    localparam int LLEN = 4;

    typedef struct {
        logic [7:0] data;
        logic       sol;
        logic       eol;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            ready;
    logic [1:0]      rden, empty, vld, sol, eol;
    logic [1:0][7:0] q, dout;
    logic [7:0]      q1;
    logic [7:0]      mem [2][MS];
    int              wp[2], rp[2], dp[2], col[2];
    int              checks, errors, cyc;
    logic            pv[2], ps[2], pe[2];
    logic [7:0]      pd[2];
    logic [7:0]      logd[2][32];
    logic            logs[2][32], loge[2][32];
    int              logc[2][32];
    int              logn[2];
    vec_t            tbl[12];
    logic            pat[4];
    int              cyc0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(1), .LINE_LEN(LLEN), .LEN_WIDTH(10)) u_dut0 (
        .Clock(clk), .Reset(rst_n), .FifoQ(q[0]), .FifoEmpty(empty[0]), .FifoRdEn(rden[0]),
        .Flush(flush), .OutData(dout[0]), .OutValid(vld[0]), .OutReady(ready),
        .OutSol(sol[0]), .OutEol(eol[0]));

    fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(2), .LINE_LEN(LLEN), .LEN_WIDTH(2)) u_dut1 (
        .Clock(clk), .Reset(rst_n), .FifoQ(q[1]), .FifoEmpty(empty[1]), .FifoRdEn(rden[1]),
        .Flush(flush), .OutData(dout[1]), .OutValid(vld[1]), .OutReady(ready),
        .OutSol(sol[1]), .OutEol(eol[1]));

    // Upstream pmi_fifo models: "noreg" for DUT0, "reg" (extra output stage) for DUT1.
    assign empty[0] = (wp[0] == rp[0]);
    assign empty[1] = (wp[1] == rp[1]);

    always @(posedge clk) begin
        if (rden[0]) begin
            q[0]  <= mem[0][rp[0] % MS];
            rp[0] <= rp[0] + 1;
        end
        if (rden[1]) begin
            q1    <= mem[1][rp[1] % MS];
            rp[1] <= rp[1] + 1;
        end
        q[1] <= q1;
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d]: got %0h expected %0h", nm, i, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        for (int i = 0; i < 2; i++) begin
            mem[i][wp[i] % MS] = d;
            wp[i]++;
        end
    endtask

    // Scoreboard: every word read upstream must come out once, in order, unless
    // a flush or reset discards everything read but not yet delivered.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk("rst_valid", i, 32'(vld[i]), 32'd0);
                chk("rst_rden",  i, 32'(rden[i]), 32'd0);
                chk("rst_sol",   i, 32'(sol[i]), 32'd1);
                chk("rst_eol",   i, 32'(eol[i]), 32'd0);
                dp[i]  = rp[i];
                col[i] = 0;
                pv[i]  = 1'b0;
            end else begin
                chk("rden_while_empty", i, 32'(rden[i] & empty[i]), 32'd0);
                chk("occupancy_bound", i, 32'(rp[i] - dp[i] <= i + 3), 32'd1);
                if (flush)
                    chk("rden_in_flush", i, 32'(rden[i]), 32'd0);
                if (pv[i]) begin
                    chk("stall_valid", i, 32'(vld[i]), 32'd1);
                    chk("stall_data",  i, 32'(dout[i]), 32'(pd[i]));
                    chk("stall_sol",   i, 32'(sol[i]), 32'(ps[i]));
                    chk("stall_eol",   i, 32'(eol[i]), 32'(pe[i]));
                end
                if (vld[i] && ready) begin
                    chk("word_source", i, 32'(dp[i] < rp[i]), 32'd1);
                    chk("data", i, 32'(dout[i]), 32'(mem[i][dp[i] % MS]));
                    chk("sol",  i, 32'(sol[i]), 32'(col[i] == 0));
                    chk("eol",  i, 32'(eol[i]), 32'(col[i] == LLEN - 1));
                    if (logn[i] < 32) begin
                        logd[i][logn[i]] = dout[i];
                        logs[i][logn[i]] = sol[i];
                        loge[i][logn[i]] = eol[i];
                        logc[i][logn[i]] = cyc;
                    end
                    logn[i]++;
                    dp[i]++;
                    col[i] = (col[i] + 1) % LLEN;
                end
                pv[i] = vld[i] && !ready && !flush;
                pd[i] = dout[i];
                ps[i] = sol[i];
                pe[i] = eol[i];
                if (flush) begin
                    dp[i]  = rp[i];
                    col[i] = 0;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        tbl = '{'{8'h00, 1'b1, 1'b0}, '{8'h01, 1'b0, 1'b0}, '{8'h02, 1'b0, 1'b0}, '{8'h03, 1'b0, 1'b1},
                '{8'h04, 1'b1, 1'b0}, '{8'h05, 1'b0, 1'b0}, '{8'h06, 1'b0, 1'b0}, '{8'h07, 1'b0, 1'b1},
                '{8'h08, 1'b1, 1'b0}, '{8'h09, 1'b0, 1'b0}, '{8'h0A, 1'b0, 1'b0}, '{8'h0B, 1'b0, 1'b1}};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; flush = 1'b0; ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0; logn[i] = 0; dp[i] = 0; col[i] = 0;
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();

        // Preloaded FIFO, ready held high: latency, gap-free run and framing.
        ready = 1'b1;
        cyc0  = cyc;
        for (int k = 0; k < 12; k++) push(8'(k));
        for (int n = 0; n < 60 && (logn[0] < 12 || logn[1] < 12); n++) step();
        for (int i = 0; i < 2; i++) begin
            chk("run_count", i, 32'(logn[i]), 32'd12);
            chk("first_latency", i, 32'(logc[i][0] - cyc0), 32'(i + 2));
            for (int k = 0; k < 12; k++) begin
                chk("tbl_data", i, 32'(logd[i][k]), 32'(tbl[k].data));
                chk("tbl_sol",  i, 32'(logs[i][k]), 32'(tbl[k].sol));
                chk("tbl_eol",  i, 32'(loge[i][k]), 32'(tbl[k].eol));
                if (k > 0)
                    chk("no_gap", i, 32'(logc[i][k] - logc[i][k-1]), 32'd1);
            end
        end
        push(8'h0C);
        for (int n = 0; n < 20 && (dp[0] != wp[0] || dp[1] != wp[1]); n++) step();

        // Flush the cycle after a read issue: the returning word must vanish.
        push(8'hF0);
        #1;
        chk("read_issue", 0, 32'(rden), 32'd3);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_drop_a", 0, 32'(vld), 32'd0);
        step();
        chk("flush_drop_b", 0, 32'(vld), 32'd0);
        logn[0] = 0; logn[1] = 0;
        push(8'hA0); push(8'hA1); push(8'hA2);
        for (int n = 0; n < 30 && (logn[0] < 3 || logn[1] < 3); n++) step();
        for (int i = 0; i < 2; i++) begin
            chk("post_flush_data", i, 32'(logd[i][0]), 32'hA0);
            chk("post_flush_sol",  i, 32'(logs[i][0]), 32'd1);
        end

        // Ready pattern 1,0,0,1 over 32 words.
        logn[0] = 0; logn[1] = 0;
        for (int k = 0; k < 32; k++) push(8'($urandom));
        for (int n = 0; n < 400 && (dp[0] != wp[0] || dp[1] != wp[1]); n++) begin
            ready = pat[n % 4];
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk("pattern_drained", i, 32'(dp[i] == wp[i]), 32'd1);
            chk("pattern_count",   i, 32'(logn[i]), 32'd32);
        end

        // Asynchronous reset in the middle of a line.
        ready = 1'b1;
        logn[0] = 0; logn[1] = 0;
        for (int k = 0; k < 8; k++) push(8'h50 + 8'(k));
        for (int n = 0; n < 30 && logn[0] < 5; n++) step();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_valid", i, 32'(vld[i]), 32'd0);
            chk("async_rden",  i, 32'(rden[i]), 32'd0);
            chk("async_sol",   i, 32'(sol[i]), 32'd1);
            chk("async_eol",   i, 32'(eol[i]), 32'd0);
        end
        step(); step();
        push(8'h60); push(8'h61); push(8'h62); push(8'h63);
        rst_n = 1'b1;
        #1;
        chk("release_no_read", 0, 32'(rden), 32'd0);
        step();
        chk("restart_read", 0, 32'(rden), 32'd3);
        logn[0] = 0; logn[1] = 0;
        for (int n = 0; n < 30 && (logn[0] < 1 || logn[1] < 1); n++) step();
        for (int i = 0; i < 2; i++)
            chk("restart_sol", i, 32'(logs[i][0]), 32'd1);
        for (int n = 0; n < 60 && (dp[0] != wp[0] || dp[1] != wp[1]); n++) step();

        // Random fill/drain, ready and occasional flush.
        for (int n = 0; n < 10000; n++) begin
            if (($urandom % 4) < 32'(1 + (n / 1250) % 3) && (wp[0] - rp[0]) < 20)
                push(8'($urandom));
            ready = (($urandom % 4) < 32'(1 + (n / 700) % 4));
            flush = (($urandom % 150) == 0);
            step();
        end
        flush = 1'b0;
        ready = 1'b1;
        for (int n = 0; n < 300 && (dp[0] != wp[0] || dp[1] != wp[1]); n++) step();
        for (int i = 0; i < 2; i++)
            chk("final_drained", i, 32'(dp[i] == wp[i]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
